press_classifier: RTL and testbench

Downstream consumer of the edge detector's single-cycle rise/fall pulses for a push-button input. Measures press duration and inter-press gap with one shared counter and classifies each gesture as a short press, a long press or a double press. Each classification is emitted as a registered one-cycle pulse to the control logic.

---
 rtl/press_classifier.sv | 100 ++++++++++
 tb/tb_press_classifier.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/press_classifier.sv
// press_classifier
//   Classifies push-button gestures from single-cycle rise/fall pulses into
//   short press, long press or double press. One shared counter times both the
//   hold (HELD1) and the release-to-press gap (GAP).
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rise_in      one-cycle press pulse from the edge detector
//   fall_in      one-cycle release pulse from the edge detector
//   short_press  one-cycle pulse: single short press completed
//   long_press   one-cycle pulse: hold reached LONG_CYCLES
//   double_press one-cycle pulse: second press of a pair released
//   busy         gesture in progress (stays high through the closing pulse)
module press_classifier #(
  parameter int LONG_CYCLES       = 50_000_000,
  parameter int DOUBLE_GAP_CYCLES = 12_500_000,
  parameter int CNT_W             = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rise_in,
  input  logic fall_in,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic busy
);

  typedef enum logic [2:0] {IDLE, HELD1, GAP, HELD2, LONG_WAIT} state_t;

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(DOUBLE_GAP_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             short_nxt, long_nxt, double_nxt;
  logic             rise, fall;

  // Simultaneous rise and fall is not a meaningful edge: drop both.
  assign rise = rise_in & ~fall_in;
  assign fall = fall_in & ~rise_in;

  always_comb begin
    state_nxt  = state;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;
    case (state)
      IDLE:      if (rise) state_nxt = HELD1;
      HELD1: begin
        // Release beats a coincident terminal count.
        if (fall) state_nxt = GAP;
        else if (cnt == LONG_TC) begin
          long_nxt  = 1'b1;
          state_nxt = LONG_WAIT;
        end
      end
      GAP: begin
        // Second press beats a coincident terminal count.
        if (rise) state_nxt = HELD2;
        else if (cnt == GAP_TC) begin
          short_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      HELD2: begin
        if (fall) begin
          double_nxt = 1'b1;
          state_nxt  = IDLE;
        end
      end
      LONG_WAIT: if (fall) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      // Only HELD1 and GAP time anything; both leave at their terminal
      // value, so the counter cannot wrap.
      if (state_nxt != state)                cnt <= '0;
      else if (state == HELD1 || state == GAP) cnt <= cnt + 1'b1;
      else                                   cnt <= '0;
      short_press  <= short_nxt;
      long_press   <= long_nxt;
      double_press <= double_nxt;
      // busy covers the cycle of the closing short/double pulse as well.
      busy         <= (state_nxt != IDLE) | short_nxt | double_nxt;
    end
  end

endmodule

// File: tb/tb_press_classifier.sv
module tb_press_classifier;
  localparam int LONG = 8;
  localparam int GAPC = 5;
  localparam int MAXC = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rise_in = 1'b0, fall_in = 1'b0;
  logic short_press, long_press, double_press, busy;

  int checks = 0;
  int errors = 0;

  // Per-cycle stimulus and {busy,double,long,short} observed/expected.
  bit       r [MAXC];
  bit       f [MAXC];
  logic [3:0] obs [MAXC];
  logic [3:0] expv [MAXC];

  press_classifier #(.LONG_CYCLES(LONG), .DOUBLE_GAP_CYCLES(GAPC), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .rise_in(rise_in), .fall_in(fall_in),
    .short_press(short_press), .long_press(long_press),
    .double_press(double_press), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic clr();
    for (int k = 0; k < MAXC; k++) begin r[k] = 0; f[k] = 0; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rise_in = 1'b0; fall_in = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Cycle k: outputs sampled mid-cycle, then inputs for k driven; they are
  // sampled by the edge that ends cycle k.
  task automatic run_seq(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      obs[k] = {busy, double_press, long_press, short_press};
      rise_in = r[k]; fall_in = f[k];
    end
    @(negedge clk);
    rise_in = 1'b0; fall_in = 1'b0;
  endtask

  // Gesture model: remembers when the current phase began and compares
  // elapsed cycles against the thresholds. Results of inputs sampled in
  // cycle k are visible in cycle k+1.
  task automatic model(input int n);
    int ph, t0;  // 0 idle, 1 first hold, 2 gap, 3 second hold, 4 long wait
    bit rv, fv, s, l, d;
    ph = 0; t0 = 0;
    expv[0] = 4'b0000;
    for (int k = 0; k < n - 1; k++) begin
      rv = r[k] && !f[k];
      fv = f[k] && !r[k];
      s = 0; l = 0; d = 0;
      case (ph)
        0: if (rv) begin ph = 1; t0 = k; end
        1: if (fv) begin ph = 2; t0 = k; end
           else if (k - t0 == LONG) begin l = 1; ph = 4; end
        2: if (rv) ph = 3;
           else if (k - t0 == GAPC) begin s = 1; ph = 0; end
        3: if (fv) begin d = 1; ph = 0; end
        default: if (fv) ph = 0;
      endcase
      expv[k+1] = {(ph != 0) || s || d, d, l, s};
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, double_press, long_press, short_press} !== 4'b0000) begin
      errors++; $display("FAIL reset_state got %b want 0000", {busy, double_press, long_press, short_press});
    end
    clr();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, double_press, long_press, short_press} !== ((k >= 1 && k <= 4) ? 4'b1000 : 4'b0000)) begin
        errors++; $display("FAIL reset_abort c%0d got %b", k, {busy, double_press, long_press, short_press});
      end
      if (k == 4) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, double_press, long_press, short_press} !== 4'b0000) begin
          errors++; $display("FAIL reset_async got %b want 0000", {busy, double_press, long_press, short_press});
        end
      end
      if (k == 6) rst_n = 1'b1;
      rise_in = (k == 0);
      fall_in = (k == 7);
    end
    rise_in = 1'b0; fall_in = 1'b0;
  endtask

  task automatic test_short();
    clr(); r[0] = 1; f[3] = 1;
    model(14); do_reset(); run_seq(14);
    for (int k = 0; k < 14; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL short c%0d got %b want %b", k, obs[k], expv[k]); end
    end
    checks++;
    if (obs[9] !== 4'b1001 || obs[10] !== 4'b0000) begin
      errors++; $display("FAIL short_pulse got %b/%b want 1001/0000", obs[9], obs[10]);
    end
  endtask

  task automatic test_long();
    clr(); r[0] = 1; f[20] = 1;
    model(26); do_reset(); run_seq(26);
    for (int k = 0; k < 26; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL long c%0d got %b want %b", k, obs[k], expv[k]); end
    end
    checks++;
    if (obs[9] !== 4'b1010 || obs[20] !== 4'b1000 || obs[21] !== 4'b0000) begin
      errors++; $display("FAIL long_pulse got %b/%b/%b want 1010/1000/0000", obs[9], obs[20], obs[21]);
    end
  endtask

  task automatic test_fall_vs_tc();
    clr(); r[0] = 1; f[8] = 1;
    model(18); do_reset(); run_seq(18);
    for (int k = 0; k < 18; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL fall_tc c%0d got %b want %b", k, obs[k], expv[k]); end
    end
    checks++;
    if (obs[9] !== 4'b1000 || obs[14] !== 4'b1001) begin
      errors++; $display("FAIL fall_tc_pulse got %b/%b want 1000/1001", obs[9], obs[14]);
    end
  endtask

  task automatic test_double();
    clr(); r[0] = 1; f[2] = 1; r[6] = 1; f[30] = 1;
    model(36); do_reset(); run_seq(36);
    for (int k = 0; k < 36; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL double c%0d got %b want %b", k, obs[k], expv[k]); end
    end
    checks++;
    if (obs[31] !== 4'b1100 || obs[32] !== 4'b0000) begin
      errors++; $display("FAIL double_pulse got %b/%b want 1100/0000", obs[31], obs[32]);
    end
  endtask

  task automatic test_gap_boundary();
    clr(); r[0] = 1; f[2] = 1; r[7] = 1; f[9] = 1;
    model(14); do_reset(); run_seq(14);
    for (int k = 0; k < 14; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL gap_in c%0d got %b want %b", k, obs[k], expv[k]); end
    end
    checks++;
    if (obs[8] !== 4'b1000 || obs[10] !== 4'b1100) begin
      errors++; $display("FAIL gap_in_pulse got %b/%b want 1000/1100", obs[8], obs[10]);
    end
    clr(); r[0] = 1; f[2] = 1; r[8] = 1; f[9] = 1;
    model(20); do_reset(); run_seq(20);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL gap_out c%0d got %b want %b", k, obs[k], expv[k]); end
    end
    checks++;
    if (obs[8] !== 4'b1001 || obs[15] !== 4'b1001 || obs[16] !== 4'b0000) begin
      errors++; $display("FAIL gap_out_pulse got %b/%b/%b want 1001/1001/0000", obs[8], obs[15], obs[16]);
    end
  endtask

  task automatic test_back_to_back();
    // double at 7, new press accepted at 7, short at 15
    clr(); r[0] = 1; f[2] = 1; r[4] = 1; f[6] = 1; r[7] = 1; f[9] = 1;
    model(20); do_reset(); run_seq(20);
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL b2b c%0d got %b want %b", k, obs[k], expv[k]); end
    end
    checks++;
    if (obs[7] !== 4'b1100 || obs[8] !== 4'b1000 || obs[15] !== 4'b1001) begin
      errors++; $display("FAIL b2b_pulse got %b/%b/%b want 1100/1000/1001", obs[7], obs[8], obs[15]);
    end
  endtask

  task automatic test_illegal();
    clr(); r[0] = 1; f[0] = 1; r[3] = 1; f[3] = 1;
    model(8); do_reset(); run_seq(8);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (obs[k] !== 4'b0000) begin errors++; $display("FAIL illegal c%0d got %b want 0000", k, obs[k]); end
    end
  endtask

  task automatic test_random(input int n, input int dens);
    clr();
    for (int k = 0; k < n; k++) begin
      r[k] = ($urandom_range(dens - 1) == 0);
      f[k] = ($urandom_range(dens - 1) == 0);
    end
    model(n); do_reset(); run_seq(n);
    for (int k = 0; k < n; k++) begin
      checks++;
      if (obs[k] !== expv[k]) begin errors++; $display("FAIL random c%0d got %b want %b", k, obs[k], expv[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_fall_vs_tc();
    test_double();
    test_gap_boundary();
    test_back_to_back();
    test_illegal();
    test_random(400, 6);
    test_random(400, 12);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
